parking_meter_ctrl: RTL and testbench

Timekeeping core for the parking-meter display path. Holds remaining time in seconds (0..9999), applies button credits and reloads, and counts down once per second. Drives the 16-bit value and a blink-enable to the downstream four-digit seven-segment display stage. Inputs come from the debounce/one-shot stage; every button input is a clean single-cycle pulse synchronous to clk.

---
 rtl/parking_meter_if.sv | 25 ++
 rtl/parking_meter_ctrl.sv | 126 ++++++++++++
 tb/tb_parking_meter_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/parking_meter_if.sv
// Button pulses from the debounce stage and the value/blink outputs
// toward the seven-segment display stage.
interface parking_meter_if;
   localparam int unsigned VAL_W = 16;

   logic             add_10;
   logic             add_180;
   logic             add_200;
   logic             add_550;
   logic             rst_10;
   logic             rst_205;
   logic [VAL_W-1:0] meter_val;
   logic             disp_on;
   logic             sec_tick;

   modport master (
      output add_10, add_180, add_200, add_550, rst_10, rst_205,
      input  meter_val, disp_on, sec_tick
   );

   modport slave (
      input  add_10, add_180, add_200, add_550, rst_10, rst_205,
      output meter_val, disp_on, sec_tick
   );
endinterface

// File: rtl/parking_meter_ctrl.sv
// Parking-meter timekeeping core: remaining seconds, button credits/reloads,
// once-per-second countdown and display blink control.
module parking_meter_ctrl #(
   parameter int unsigned TICK_CYCLES = 100000000,
   parameter int unsigned MAX_VAL     = 9999,
   parameter int unsigned LOW_THRESH  = 200
) (
   input  logic           clk,
   input  logic           reset,
   parking_meter_if.slave pm
);
   localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int unsigned VAL_W = 16;
   localparam int unsigned SUM_W = VAL_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_CYCLES / 2);
   localparam logic [VAL_W-1:0] VAL_MAX  = VAL_W'(MAX_VAL);
   localparam logic [VAL_W-1:0] VAL_LOW  = VAL_W'(LOW_THRESH);

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_LOW    = 2'd1,
      ST_NORMAL = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic             half_flag_q, half_flag_d;
   logic             sec_parity_q, sec_parity_d;
   logic [VAL_W-1:0] meter_q, meter_d;
   logic             disp_on_q, disp_on_d;
   logic             sec_tick_q, sec_tick_d;
   logic             wrap_c;
   logic             add_req_c;
   logic [VAL_W-1:0] add_amt_c;
   logic [SUM_W-1:0] sum_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_EMPTY;
         tick_cnt_q   <= '0;
         half_flag_q  <= 1'b0;
         sec_parity_q <= 1'b0;
         meter_q      <= '0;
         disp_on_q    <= 1'b1;
         sec_tick_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick_cnt_q   <= tick_cnt_d;
         half_flag_q  <= half_flag_d;
         sec_parity_q <= sec_parity_d;
         meter_q      <= meter_d;
         disp_on_q    <= disp_on_d;
         sec_tick_q   <= sec_tick_d;
      end
   end

   always_comb begin
      tick_cnt_d   = tick_cnt_q + CNT_W'(1);
      sec_parity_d = sec_parity_q;
      meter_d      = meter_q;
      state_d      = state_q;
      disp_on_d    = disp_on_q;
      add_req_c    = 1'b0;
      add_amt_c    = '0;
      sum_c        = '0;
      wrap_c       = (tick_cnt_q == CNT_LAST);
      sec_tick_d   = wrap_c;

      if (wrap_c) begin
         tick_cnt_d = '0;
      end

      // One action per cycle; a button pre-empts the decrement of this second.
      if (pm.rst_205) begin
         meter_d      = VAL_W'(205);
         tick_cnt_d   = '0;
         sec_parity_d = 1'b0;
      end else if (pm.rst_10) begin
         meter_d      = VAL_W'(10);
         tick_cnt_d   = '0;
         sec_parity_d = 1'b0;
      end else if (pm.add_550) begin
         add_req_c = 1'b1;
         add_amt_c = VAL_W'(550);
      end else if (pm.add_200) begin
         add_req_c = 1'b1;
         add_amt_c = VAL_W'(200);
      end else if (pm.add_180) begin
         add_req_c = 1'b1;
         add_amt_c = VAL_W'(180);
      end else if (pm.add_10) begin
         add_req_c = 1'b1;
         add_amt_c = VAL_W'(10);
      end else if (wrap_c && (meter_q != '0)) begin
         meter_d      = meter_q - VAL_W'(1);
         sec_parity_d = ~sec_parity_q;
      end

      if (add_req_c) begin
         sum_c   = SUM_W'(meter_q) + SUM_W'(add_amt_c);
         meter_d = (sum_c > SUM_W'(MAX_VAL)) ? VAL_MAX : sum_c[VAL_W-1:0];
      end

      half_flag_d = (tick_cnt_d >= CNT_HALF);

      if (meter_d == '0) begin
         state_d = ST_EMPTY;
      end else if (meter_d < VAL_LOW) begin
         state_d = ST_LOW;
      end else begin
         state_d = ST_NORMAL;
      end

      // LOW blinks at 2 s period from second parity, EMPTY at 1 s from the half-second flag.
      unique case (state_q)
         ST_NORMAL: disp_on_d = 1'b1;
         ST_LOW:    disp_on_d = ~sec_parity_q;
         default:   disp_on_d = ~half_flag_q;
      endcase
   end

   assign pm.meter_val = meter_q;
   assign pm.disp_on   = disp_on_q;
   assign pm.sec_tick  = sec_tick_q;
endmodule

// File: tb/tb_parking_meter_ctrl.sv
// Bench for parking_meter_ctrl: directed scenarios with literal expectations
// plus randomized buttons checked every cycle against a behavioural model.
module tb_parking_meter_ctrl;
   localparam int unsigned TICK = 10;
   localparam int unsigned MAXV = 9999;
   localparam int unsigned LOWT = 200;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] btn;   // {rst_205, rst_10, add_550, add_200, add_180, add_10}

   parking_meter_if pm ();

   assign {pm.rst_205, pm.rst_10, pm.add_550, pm.add_200, pm.add_180, pm.add_10} = btn;

   parking_meter_ctrl #(
      .TICK_CYCLES (TICK),
      .MAX_VAL     (MAXV),
      .LOW_THRESH  (LOWT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .pm    (pm.slave)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Model: seconds left, position inside the current second, LOW-blink parity.
   int m_val, m_cnt, m_amt;
   bit m_par, m_disp, m_tick, m_wrapped;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_val = 0; m_cnt = 0; m_par = 0; m_disp = 1; m_tick = 0;
      end else begin
         if (m_val >= int'(LOWT))  m_disp = 1'b1;
         else if (m_val > 0)       m_disp = !m_par;
         else                      m_disp = (m_cnt < int'(TICK / 2));
         m_wrapped = (m_cnt == int'(TICK) - 1);
         m_tick    = m_wrapped;
         m_cnt     = (m_cnt + 1) % int'(TICK);
         if (btn[5] || btn[4]) begin
            m_val = btn[5] ? 205 : 10;
            m_cnt = 0;
            m_par = 0;
         end else if (btn[3:0] != 4'b0) begin
            m_amt = btn[3] ? 550 : btn[2] ? 200 : btn[1] ? 180 : 10;
            m_val = (m_val + m_amt > int'(MAXV)) ? int'(MAXV) : m_val + m_amt;
         end else if (m_wrapped && m_val > 0) begin
            m_val = m_val - 1;
            m_par = !m_par;
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         check("meter_val", int'(pm.meter_val), m_val);
         check("disp_on", int'(pm.disp_on), int'(m_disp));
         check("sec_tick", int'(pm.sec_tick), int'(m_tick));
      end
   end

   task automatic press(input logic [5:0] b);
      btn = b;
      @(negedge clk);
      btn = '0;
   endtask

   task automatic wait_tick(input int bound, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!pm.sec_tick && cycles < bound);
      check("sec_tick_wait", int'(pm.sec_tick), 1);
   endtask

   task automatic count_disp(input int n, output int ones);
      ones = 0;
      repeat (n) begin
         @(negedge clk);
         ones += int'(pm.disp_on);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, ones, ticks, r;
      logic [5:0] b;
      btn   = '0;
      reset = 1'b0;
      #22 reset = 1'b1;
      @(negedge clk);
      check("rst_meter", int'(pm.meter_val), 0);
      check("rst_disp", int'(pm.disp_on), 1);
      check("rst_tick", int'(pm.sec_tick), 0);

      ones = 0; ticks = 0;
      repeat (50) begin
         @(negedge clk);
         ones  += int'(pm.disp_on);
         ticks += int'(pm.sec_tick);
      end
      check("idle_disp_cycles", ones, 25);
      check("idle_ticks", ticks, 5);
      check("idle_meter", int'(pm.meter_val), 0);

      press(6'b100000);
      check("load_205", int'(pm.meter_val), 205);
      check("load_205_disp", int'(pm.disp_on), 1);
      for (int i = 1; i <= 6; i++) begin
         wait_tick(20, cyc);
         check("countdown", int'(pm.meter_val), 205 - i);
      end
      wait_tick(20, cyc);
      check("countdown_198", int'(pm.meter_val), 198);
      count_disp(10, ones);
      check("low_blink_off", ones, 0);
      count_disp(10, ones);
      check("low_blink_on", ones, 10);

      press(6'b010000);
      repeat (18) press(6'b001000);
      check("add550_x18", int'(pm.meter_val), 9910);
      press(6'b001000);
      check("sat_9999", int'(pm.meter_val), 9999);
      press(6'b000001);
      check("sat_hold", int'(pm.meter_val), 9999);

      press(6'b011000);
      check("rst10_beats_add", int'(pm.meter_val), 10);
      wait_tick(20, cyc);
      check("second_restart_len", cyc, 10);
      check("after_restart", int'(pm.meter_val), 9);
      press(6'b110000);
      check("rst205_beats_rst10", int'(pm.meter_val), 205);

      press(6'b010000);
      repeat (4) press(6'b000001);
      check("build_50", int'(pm.meter_val), 50);
      cyc = 0;
      while (m_cnt != int'(TICK) - 1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      press(6'b000001);
      check("add_at_wrap", int'(pm.meter_val), 60);
      check("add_at_wrap_tick", int'(pm.sec_tick), 1);
      wait_tick(20, cyc);
      check("after_add_wrap", int'(pm.meter_val), 59);

      press(6'b010000);
      repeat (11) wait_tick(20, cyc);
      check("empty_after_11", int'(pm.meter_val), 0);
      wait_tick(20, cyc);
      check("empty_hold", int'(pm.meter_val), 0);
      count_disp(10, ones);
      check("empty_blink", ones, 5);
      cyc = 0;
      while (pm.disp_on && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("blink_low_phase", int'(pm.disp_on), 0);
      #2 reset = 1'b0;
      #1;
      check("async_disp", int'(pm.disp_on), 1);
      check("async_meter", int'(pm.meter_val), 0);
      check("async_tick", int'(pm.sec_tick), 0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            #2 reset = 1'b0;
            #1;
            check("rand_async_meter", int'(pm.meter_val), 0);
            check("rand_async_disp", int'(pm.disp_on), 1);
            @(negedge clk);
            reset = 1'b1;
         end
         r = int'($urandom_range(0, 99));
         if (r < 2)       b = 6'($urandom);
         else if (r < 4)  b = 6'(1 << $urandom_range(4, 5));
         else if (r < 6)  b = 6'(1 << $urandom_range(0, 3));
         else             b = '0;
         btn = b;
         @(negedge clk);
      end
      btn = '0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
